booth_mult_seq: RTL

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq_pkg.sv | 31 +++
 rtl/booth_mult_seq_decoder.sv | 31 +++
 rtl/booth_mult_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// the Booth digit select encoding and the step-count derivation.
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A radix-4 digit in {0, +-1, +-2}: neg selects inversion, one/two the magnitude.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  function automatic int booth_steps(input int w);
    return w / 2;
  endfunction

  // Window {y[2k+1], y[2k], y[2k-1]} to digit; 111 and 000 both mean zero.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    d.neg = win[2] & ~(win[1] & win[0]);
    d.one = win[1] ^ win[0];
    d.two = (win == 3'b011) || (win == 3'b100);
    return d;
  endfunction

endpackage

// File: rtl/booth_mult_seq_decoder.sv
// Radix-4 Booth digit decoder: selects 0, x or 2x (W+1 bits) and inverts it
// for negative digits; the +1 that completes the negation leaves as cin.
module booth_decoder
  import booth_mult_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [2:0]   window,
  output logic [W:0]   mag,
  output logic         cin
);

  booth_digit_t digit;
  logic [W:0]   sel;

  assign digit = booth_decode(window);

  always_comb begin
    sel = '0;
    if (digit.one) begin
      sel = {x[W-1], x};
    end else if (digit.two) begin
      sel = {x, 1'b0};
    end
  end

  assign mag = digit.neg ? ~sel : sel;
  assign cin = digit.neg;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed W x W multiplier retiring one radix-4 Booth digit per
// cycle; IDLE -> RUN (STEPS cycles) -> DONE, with valid/ready on both sides.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int W = 16  // operand width, even and >= 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x_in,
  input  logic [W-1:0]   y_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p_out,
  output logic           busy,
  output state_t         fsm_state
);

  localparam int STEPS = booth_steps(W);
  localparam int KW    = $clog2(STEPS);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and out_valid/p_out hold until taken.

  state_t         state;
  logic [KW-1:0]  k;
  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic [2*W-1:0] acc;

  logic [W:0]     y_ext;
  logic [KW:0]    shamt;
  logic [2:0]     window;
  logic [W:0]     mag;
  logic           cin;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] pp_cin;
  logic [2*W-1:0] acc_next;
  logic           accept;
  logic           last_step;

  // y[-1] = 0 is the appended LSB, so window k starts at bit 2k of y_ext.
  assign y_ext  = {y_q, 1'b0};
  assign shamt  = {k, 1'b0};
  assign window = y_ext[shamt +: 3];

  booth_decoder #(.W(W)) u_dec (
    .x      (x_q),
    .window (window),
    .mag    (mag),
    .cin    (cin)
  );

  // Inverted magnitude plus a carry at bit 2k forms the negative digit.
  assign pp       = {{(W-1){mag[W]}}, mag} << shamt;
  assign pp_cin   = {{(2*W-1){1'b0}}, cin} << shamt;
  assign acc_next = acc + pp + pp_cin;

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (k == KW'(STEPS - 1));

  assign p_out     = acc;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            x_q   <= x_in;
            y_q   <= y_in;
            acc   <= '0;
            k     <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          if (last_step) begin
            k         <= '0;
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              x_q   <= x_in;
              y_q   <= y_in;
              acc   <= '0;
              k     <= '0;
              state <= S_RUN;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
